// File: rtl/class_fifo_pkg.sv
// rtl/class_fifo_pkg.sv - shared word layout and class constants for the class FIFO bank and its arbiter.
package class_fifo_pkg;

  localparam int NUM_CLASSES = 4;
  localparam int CLASS_MSB   = 11;
  localparam int CLASS_LSB   = 10;
  localparam int DEST_MSB    = 9;
  localparam int DEST_LSB    = 8;
  localparam int DATA_MSB    = 7;

  typedef logic [CLASS_MSB-CLASS_LSB:0] class_t;

  typedef struct packed {
    class_t               cls;
    logic [DEST_MSB-DEST_LSB:0] dest;
    logic [DATA_MSB:0]    payload;
  } word_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered read port and occupancy-decoded flags.
module sync_fifo
  import class_fifo_pkg::*;
#(
  parameter int W         = 12,
  parameter int DEPTH     = 8,
  parameter int PTR_W     = 3,
  parameter int AF_THRESH = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         almost_full,
  output logic         full,
  output logic         push_drop,
  output logic         pop_reject
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] AF_C    = (PTR_W+1)'(AF_THRESH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [W-1:0]     dout_q, dout_d;
  logic             push_ok, pop_ok;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;

    // A pop frees a slot in the same edge, so a full FIFO still takes a concurrent push.
    pop_ok  = pop && (count_q != '0);
    push_ok = push && ((count_q != DEPTH_C) || pop_ok);

    if (pop_ok) begin
      dout_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is never cleared; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign dout        = dout_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);
  assign push_drop   = push && !push_ok;
  assign pop_reject  = pop && !pop_ok;

endmodule

// File: rtl/class_fifo_bank.sv
// rtl/class_fifo_bank.sv - steers incoming words by class into four FIFOs feeding the class arbiter.
// Optional per-class drop counters are built when CLASS_FIFO_DROP_CNT_EN is defined.
module class_fifo_bank
  import class_fifo_pkg::*;
#(
  parameter int WORD_SIZE  = 12,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_SIZE-1:0]   data_in,
  input  logic                   push_in,
  input  logic [NUM_CLASSES-1:0] fifos_pop,
  output logic [WORD_SIZE-1:0]   fifo_data_out0,
  output logic [WORD_SIZE-1:0]   fifo_data_out1,
  output logic [WORD_SIZE-1:0]   fifo_data_out2,
  output logic [WORD_SIZE-1:0]   fifo_data_out3,
  output logic [NUM_CLASSES-1:0] fifos_empty,
  output logic [NUM_CLASSES-1:0] fifos_almost_full,
  output logic [NUM_CLASSES-1:0] fifos_full,
  output logic [NUM_CLASSES-1:0] overflow_err,
`ifdef CLASS_FIFO_DROP_CNT_EN
  output logic [NUM_CLASSES-1:0] underflow_err,
  output logic [31:0]            drop_count
`else
  output logic [NUM_CLASSES-1:0] underflow_err
`endif
);

  class_t                 in_cls;
  logic [NUM_CLASSES-1:0] push_vec;
  logic [NUM_CLASSES-1:0] drop_w, reject_w;
  logic [WORD_SIZE-1:0]   dout_w [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] overflow_q, overflow_d;
  logic [NUM_CLASSES-1:0] underflow_q, underflow_d;

  assign in_cls = data_in[CLASS_MSB:CLASS_LSB];

  always_comb begin
    push_vec = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      push_vec[k] = push_in && (in_cls == class_t'(k));
    end
  end

  for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_fifo
    sync_fifo #(
      .W         (WORD_SIZE),
      .DEPTH     (FIFO_DEPTH),
      .PTR_W     (PTR_W),
      .AF_THRESH (AF_THRESH)
    ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (push_vec[k]),
      .din         (data_in),
      .pop         (fifos_pop[k]),
      .dout        (dout_w[k]),
      .empty       (fifos_empty[k]),
      .almost_full (fifos_almost_full[k]),
      .full        (fifos_full[k]),
      .push_drop   (drop_w[k]),
      .pop_reject  (reject_w[k])
    );
  end

  assign fifo_data_out0 = dout_w[0];
  assign fifo_data_out1 = dout_w[1];
  assign fifo_data_out2 = dout_w[2];
  assign fifo_data_out3 = dout_w[3];

  // Error strobes are registered so they line up with the flags of the same edge.
  always_comb begin
    overflow_d  = drop_w;
    underflow_d = reject_w;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_q  <= '0;
      underflow_q <= '0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow_err  = overflow_q;
  assign underflow_err = underflow_q;

`ifdef CLASS_FIFO_DROP_CNT_EN
  logic [7:0] drop_cnt_q [NUM_CLASSES];
  logic [7:0] drop_cnt_d [NUM_CLASSES];

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (drop_w[k] && (drop_cnt_q[k] != 8'hFF)) begin
        drop_cnt_d[k] = drop_cnt_q[k] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CLASSES; k++) begin
        drop_cnt_q[k] <= '0;
      end
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_count = {drop_cnt_q[3], drop_cnt_q[2], drop_cnt_q[1], drop_cnt_q[0]};
`endif

endmodule

// File: tb/tb_class_fifo_bank.sv
// tb/tb_class_fifo_bank.sv - self-checking bench for class_fifo_bank against a queue-based model.
module tb_class_fifo_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] data_in;
  logic        push_in;
  logic [3:0]  fifos_pop;
  logic [11:0] fifo_data_out0, fifo_data_out1, fifo_data_out2, fifo_data_out3;
  logic [3:0]  fifos_empty, fifos_almost_full, fifos_full, overflow_err, underflow_err;
`ifdef CLASS_FIFO_DROP_CNT_EN
  logic [31:0] drop_count;
`endif

  always #5 clk = ~clk;

  class_fifo_bank dut (
    .clk               (clk),
    .reset             (reset),
    .data_in           (data_in),
    .push_in           (push_in),
    .fifos_pop         (fifos_pop),
    .fifo_data_out0    (fifo_data_out0),
    .fifo_data_out1    (fifo_data_out1),
    .fifo_data_out2    (fifo_data_out2),
    .fifo_data_out3    (fifo_data_out3),
    .fifos_empty       (fifos_empty),
    .fifos_almost_full (fifos_almost_full),
    .fifos_full        (fifos_full),
    .overflow_err      (overflow_err),
`ifdef CLASS_FIFO_DROP_CNT_EN
    .underflow_err     (underflow_err),
    .drop_count        (drop_count)
`else
    .underflow_err     (underflow_err)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Reference model: one queue per class plus the last popped word per class.
  logic [11:0] mq [4][$];
  logic [11:0] exp_dout [4];
  logic [3:0]  exp_ovf, exp_unf;
  logic [7:0]  exp_drop [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rst, input logic psh, input logic [11:0] d,
                            input logic [3:0] pp);
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        exp_dout[k] = '0;
        exp_drop[k] = '0;
      end
      exp_ovf = '0;
      exp_unf = '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        bit had_words = (mq[k].size() > 0);
        bit push_here = psh && (int'(d[11:10]) == k);
        bit pop_ok    = pp[k] && had_words;
        bit push_ok   = push_here && ((mq[k].size() < 8) || pop_ok);
        if (pop_ok) exp_dout[k] = mq[k].pop_front();
        if (push_ok) mq[k].push_back(d);
        exp_ovf[k] = push_here && !push_ok;
        exp_unf[k] = pp[k] && !had_words;
        if (exp_ovf[k] && exp_drop[k] != 8'hFF) exp_drop[k] = exp_drop[k] + 8'd1;
      end
    end
  endtask

  task automatic step(input logic rst, input logic psh, input logic [11:0] d, input logic [3:0] pp);
    reset     = rst;
    push_in   = psh;
    data_in   = d;
    fifos_pop = pp;
    @(posedge clk);
    model_edge(rst, psh, d, pp);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      logic [3:0] e_empty, e_af, e_full;
      for (int k = 0; k < 4; k++) begin
        e_empty[k] = (mq[k].size() == 0);
        e_af[k]    = (mq[k].size() >= 6);
        e_full[k]  = (mq[k].size() == 8);
      end
      check("data_out0", 32'(fifo_data_out0), 32'(exp_dout[0]));
      check("data_out1", 32'(fifo_data_out1), 32'(exp_dout[1]));
      check("data_out2", 32'(fifo_data_out2), 32'(exp_dout[2]));
      check("data_out3", 32'(fifo_data_out3), 32'(exp_dout[3]));
      check("empty", 32'(fifos_empty), 32'(e_empty));
      check("almost_full", 32'(fifos_almost_full), 32'(e_af));
      check("full", 32'(fifos_full), 32'(e_full));
      check("overflow_err", 32'(overflow_err), 32'(exp_ovf));
      check("underflow_err", 32'(underflow_err), 32'(exp_unf));
`ifdef CLASS_FIFO_DROP_CNT_EN
      check("drop_count", drop_count, {exp_drop[3], exp_drop[2], exp_drop[1], exp_drop[0]});
`endif
    end
  end

  initial begin
    reset = 1'b0; push_in = 1'b0; data_in = '0; fifos_pop = '0;
    @(negedge clk);

    // 1: reset held two cycles
    step(1'b0, 1'b0, 12'h000, 4'b0000);
    check_en = 1'b1;
    step(1'b0, 1'b0, 12'h000, 4'b0000);
    check("rst_empty", 32'(fifos_empty), 32'h0000000F);
    check("rst_full", 32'(fifos_full), 32'h0);
    check("rst_dout0", 32'(fifo_data_out0), 32'h0);

    // 2: single push/pop on class 0
    step(1'b1, 1'b1, 12'h0A5, 4'b0000);
    check("t2_empty_after_push", 32'(fifos_empty), 32'h0000000E);
    step(1'b1, 1'b0, 12'h000, 4'b0001);
    check("t2_dout0", 32'(fifo_data_out0), 32'h0A5);
    check("t2_empty_after_pop", 32'(fifos_empty), 32'h0000000F);

    // 3: fill class 2, then overflow
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 12'h800 + 12'(i), 4'b0000);
    check("t3_af", 32'(fifos_almost_full), 32'h4);
    for (int i = 6; i < 8; i++) step(1'b1, 1'b1, 12'h800 + 12'(i), 4'b0000);
    check("t3_full", 32'(fifos_full), 32'h4);
    step(1'b1, 1'b1, 12'h8EE, 4'b0000);
    check("t3_ovf", 32'(overflow_err), 32'h4);
`ifdef CLASS_FIFO_DROP_CNT_EN
    check("t3_drop", 32'(drop_count[23:16]), 32'h1);
`endif
    step(1'b1, 1'b0, 12'h000, 4'b0000);
    check("t3_ovf_clear", 32'(overflow_err), 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 12'h000, 4'b0100);
    check("t3_last_out", 32'(fifo_data_out2), 32'h807);

    // 4: full class 1 with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 12'h400 + 12'(i), 4'b0000);
    step(1'b1, 1'b1, 12'h5FF, 4'b0010);
    check("t4_oldest", 32'(fifo_data_out1), 32'h400);
    check("t4_still_full", 32'(fifos_full), 32'h2);
    check("t4_no_ovf", 32'(overflow_err), 32'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 12'h000, 4'b0010);
    check("t4_newest_last", 32'(fifo_data_out1), 32'h5FF);

    // 5: underflow on class 3, push+pop on empty, interleaved classes
    step(1'b1, 1'b0, 12'h000, 4'b1000);
    check("t5_unf", 32'(underflow_err), 32'h8);
    check("t5_dout3_held", 32'(fifo_data_out3), 32'h0);
    step(1'b1, 1'b1, 12'hC3C, 4'b1000);
    check("t5_empty_pushpop_unf", 32'(underflow_err), 32'h8);
    check("t5_empty_pushpop_stored", 32'(fifos_empty), 32'h7);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, {2'(i % 4), 2'(i / 4), 8'(8'h30 + i)}, 4'b0000);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 12'h000, 4'b1111);
    check("t5_dout0_last", 32'(fifo_data_out0), 32'h238);
    check("t5_dout3_last", 32'(fifo_data_out3), 32'hE3B);
    check("t5_all_empty", 32'(fifos_empty), 32'hF);

    // 6: reset with words queued
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 12'h011 + 12'(i), 4'b0000);
    step(1'b0, 1'b0, 12'h000, 4'b0000);
    check("t6_empty_after_rst", 32'(fifos_empty), 32'hF);
    check("t6_dout0_after_rst", 32'(fifo_data_out0), 32'h0);
    step(1'b1, 1'b0, 12'h000, 4'b0001);
    check("t6_unf", 32'(underflow_err), 32'h1);
    step(1'b1, 1'b0, 12'h000, 4'b0000);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
